// File: rtl/spi_slave_clk_engine_pkg.sv
// Shared types for the SPI slave clock/shift engine.
package spi_slave_clk_engine_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // Bit counter must be able to hold the frame length itself.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer plus edge detect against one extra register.
// Edge direction is recovered from the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign edge_o = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/spi_slave_clk_engine.sv
// Slave-side SPI engine: oversampled SCK/SS_n/MOSI, shift/sample strobes,
// one-word TX and RX buffers, MISO drive.
module spi_slave_clk_engine
  import spi_slave_clk_engine_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SPE,
  input  logic                  MSTR,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  LSBFE,
  input  logic                  SCK_in,
  input  logic                  SS_n,
  input  logic                  MOSI,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  input  logic                  rx_read,
  output logic                  MISO,
  output logic                  MISO_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_full,
  output logic                  overrun,
  output logic                  tx_empty,
  output logic                  S_BaudRate,
  output logic                  S_Shift_clk,
  output logic                  S_Sample_clk
);

  localparam int                CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-1:0]   shift_q, rx_shift_q, tx_buf_q, rx_data_q, rx_word;
  logic                    tx_empty_q, rx_valid_q, rx_full_q, overrun_q, miso_oe_q;
  logic                    baud_q, shift_clk_q, sample_clk_q;
  logic                    cpol_q, cpha_q, lsbfe_q;
  logic [SYNC_STAGES-1:0]  mosi_sync_q;
  logic                    sck_s, sck_edge, ss_s, ss_edge, mosi_s;
  logic                    en, ss_fall, in_active, sck_lead, sck_trail;
  logic                    sample_edge, shift_edge, frame_done, store_rx;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .d_i(SCK_in), .sync_o(sck_s), .edge_o(sck_edge)
  );

  // SS_n resets to the deselected level so reset release never looks like a select.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .d_i(SS_n), .sync_o(ss_s), .edge_o(ss_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign en          = SPE & ~MSTR & ~ss_s;
  assign ss_fall     = ss_edge & ~ss_s;
  assign in_active   = (state_q == ACTIVE) & en;
  assign sck_lead    = sck_edge & (sck_s ^ cpol_q);
  assign sck_trail   = sck_edge & ~(sck_s ^ cpol_q);
  assign sample_edge = in_active & (cpha_q ? sck_trail : sck_lead);
  assign shift_edge  = in_active & (cpha_q ? sck_lead : sck_trail);
  assign frame_done  = sample_edge & (bit_cnt_q == LAST_BIT);
  assign store_rx    = frame_done & (~rx_full_q | rx_read);
  assign rx_word     = lsbfe_q ? {mosi_s, rx_shift_q[DATA_WIDTH-1:1]}
                               : {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = LOAD;
      LOAD:    state_d = ACTIVE;
      ACTIVE:  if (frame_done) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_shift_q   <= '0;
      tx_buf_q     <= '0;
      rx_data_q    <= '0;
      tx_empty_q   <= 1'b1;
      rx_valid_q   <= 1'b0;
      rx_full_q    <= 1'b0;
      overrun_q    <= 1'b0;
      miso_oe_q    <= 1'b0;
      baud_q       <= 1'b0;
      shift_clk_q  <= 1'b0;
      sample_clk_q <= 1'b0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      lsbfe_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= in_active & sck_edge;
      shift_clk_q  <= shift_edge;
      sample_clk_q <= sample_edge;
      // Enable follows the first loaded shifter and stays up across back-to-back frames.
      miso_oe_q    <= (state_d != IDLE) & (state_q != IDLE);

      if (state_d == IDLE) begin
        bit_cnt_q <= '0;
      end else if (state_q == LOAD) begin
        bit_cnt_q <= '0;
        cpol_q    <= CPOL;
        cpha_q    <= CPHA;
        lsbfe_q   <= LSBFE;
        shift_q   <= tx_load ? tx_data : (tx_empty_q ? '0 : tx_buf_q);
      end else begin
        if (sample_edge) begin
          bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
          rx_shift_q <= rx_word;
        end
        // No bit has been presented yet when bit_cnt is zero, so that edge only confirms bit 0.
        if (shift_edge && bit_cnt_q != '0)
          shift_q <= lsbfe_q ? (shift_q >> 1) : (shift_q << 1);
      end

      if (state_q == LOAD) begin
        tx_empty_q <= 1'b1;
      end else if (tx_load) begin
        tx_buf_q   <= tx_data;
        tx_empty_q <= 1'b0;
      end

      rx_valid_q <= store_rx;
      if (store_rx) begin
        rx_data_q <= rx_word;
        rx_full_q <= 1'b1;
      end else if (rx_read) begin
        rx_full_q <= 1'b0;
      end

      if (frame_done && rx_full_q && !rx_read) overrun_q <= 1'b1;
      else if (rx_read)                        overrun_q <= 1'b0;
    end
  end

  assign MISO         = miso_oe_q & (lsbfe_q ? shift_q[0] : shift_q[DATA_WIDTH-1]);
  assign MISO_oe      = miso_oe_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_full      = rx_full_q;
  assign overrun      = overrun_q;
  assign tx_empty     = tx_empty_q;
  assign S_BaudRate   = baud_q;
  assign S_Shift_clk  = shift_clk_q;
  assign S_Sample_clk = sample_clk_q;

endmodule

// File: tb/tb_spi_slave_clk_engine.sv
// Directed bench: table of full frames plus hand-written corner sequences.
module tb_spi_slave_clk_engine;

  localparam int DW   = 8;
  localparam int HALF = 4;

  logic          clk = 1'b0, rst_n = 1'b0, SPE = 1'b0, MSTR = 1'b0;
  logic          CPOL = 1'b0, CPHA = 1'b0, LSBFE = 1'b0;
  logic          SCK_in = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_load = 1'b0, rx_read = 1'b0;
  logic          MISO, MISO_oe, rx_valid, rx_full, overrun, tx_empty;
  logic          S_BaudRate, S_Shift_clk, S_Sample_clk;
  logic [DW-1:0] rx_data;

  spi_slave_clk_engine #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SPE(SPE), .MSTR(MSTR), .CPOL(CPOL), .CPHA(CPHA),
    .LSBFE(LSBFE), .SCK_in(SCK_in), .SS_n(SS_n), .MOSI(MOSI), .tx_data(tx_data),
    .tx_load(tx_load), .rx_read(rx_read), .MISO(MISO), .MISO_oe(MISO_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full), .overrun(overrun),
    .tx_empty(tx_empty), .S_BaudRate(S_BaudRate), .S_Shift_clk(S_Shift_clk),
    .S_Sample_clk(S_Sample_clk)
  );

  always #5 clk = ~clk;

  int n_sample = 0, n_shift = 0, n_baud = 0, n_valid = 0, n_oe = 0;
  always @(negedge clk) begin
    if (S_Sample_clk) n_sample <= n_sample + 1;
    if (S_Shift_clk)  n_shift  <= n_shift + 1;
    if (S_BaudRate)   n_baud   <= n_baud + 1;
    if (rx_valid)     n_valid  <= n_valid + 1;
    if (MISO_oe)      n_oe     <= n_oe + 1;
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tx(input logic [DW-1:0] d);
    tx_data = d; tx_load = 1'b1;
    clk_wait(1);
    tx_load = 1'b0;
  endtask

  task automatic pulse_read;
    rx_read = 1'b1;
    clk_wait(1);
    rx_read = 1'b0;
    clk_wait(1);
  endtask

  task automatic ss_begin;
    SCK_in = CPOL;
    clk_wait(HALF);
    SS_n = 1'b0;
    clk_wait(2 * HALF);
  endtask

  task automatic ss_end;
    clk_wait(HALF);
    SS_n = 1'b1;
    clk_wait(2 * HALF);
  endtask

  // Master model: seq collects MISO in transmission order, first bit ending up at the top.
  task automatic xfer(input logic [DW-1:0] w, input int nbits, output logic [DW-1:0] seq);
    int idx;
    seq = '0;
    for (int k = 0; k < nbits; k++) begin
      idx = LSBFE ? k : DW - 1 - k;
      if (!CPHA) begin
        MOSI = w[idx];
        clk_wait(HALF);
        seq = {seq[DW-2:0], MISO};
        SCK_in = ~CPOL;
        clk_wait(HALF);
        SCK_in = CPOL;
      end else begin
        SCK_in = ~CPOL;
        MOSI = w[idx];
        clk_wait(HALF);
        seq = {seq[DW-2:0], MISO};
        SCK_in = CPOL;
        clk_wait(HALF);
      end
    end
  endtask

  typedef struct {
    logic          cpol, cpha, lsbfe, load;
    logic [DW-1:0] tx, mosi, exp_seq, exp_rx;
  } vec_t;

  vec_t          vecs[6];
  logic [DW-1:0] seq, seq2;
  int            s_sample, s_shift, s_baud, s_valid, s_oe;

  task automatic snap;
    s_sample = n_sample; s_shift = n_shift; s_baud = n_baud; s_valid = n_valid; s_oe = n_oe;
  endtask

  initial begin
    //          cpol  cpha  lsbfe load  tx     mosi   seq    rx
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h96, 8'h2D, 8'h96, 8'h2D};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h1E, 8'hB4, 8'h78, 8'hB4};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h80, 8'h80, 8'h80};

    clk_wait(3);
    check("rst_MISO", MISO, 0);
    check("rst_MISO_oe", MISO_oe, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_full", rx_full, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_strobes", {S_BaudRate, S_Shift_clk, S_Sample_clk}, 0);
    SPE = 1'b1;
    rst_n = 1'b1;
    clk_wait(4);

    for (int i = 0; i < 6; i++) begin
      CPOL = vecs[i].cpol; CPHA = vecs[i].cpha; LSBFE = vecs[i].lsbfe;
      if (vecs[i].load) pulse_tx(vecs[i].tx);
      check("tx_empty_pre", tx_empty, {31'd0, ~vecs[i].load});
      snap();
      ss_begin();
      xfer(vecs[i].mosi, DW, seq);
      ss_end();
      check("miso_seq", seq, vecs[i].exp_seq);
      check("rx_data", rx_data, vecs[i].exp_rx);
      check("rx_valid_cnt", n_valid - s_valid, 1);
      check("rx_full", rx_full, 1);
      check("overrun", overrun, 0);
      check("sample_cnt", n_sample - s_sample, 8);
      check("shift_cnt", n_shift - s_shift, 8);
      check("baud_cnt", n_baud - s_baud, 16);
      check("tx_empty_post", tx_empty, 1);
      check("oe_after", MISO_oe, 0);
      pulse_read();
      check("rx_full_cleared", rx_full, 0);
      $display("[TB] frame %0d cpol=%0d cpha=%0d lsbfe=%0d miso=0x%02h rx=0x%02h",
               i, CPOL, CPHA, LSBFE, seq, rx_data);
    end

    // Back-to-back frames without reading: second frame overruns.
    CPOL = 1'b0; CPHA = 1'b0; LSBFE = 1'b0;
    pulse_tx(8'h5A);
    snap();
    ss_begin();
    xfer(8'h11, DW, seq);
    xfer(8'h22, DW, seq2);
    ss_end();
    check("b2b_seq1", seq, 8'h5A);
    check("b2b_seq2", seq2, 8'h00);
    check("b2b_rx_data", rx_data, 8'h11);
    check("b2b_overrun", overrun, 1);
    check("b2b_rx_full", rx_full, 1);
    check("b2b_valid_cnt", n_valid - s_valid, 1);
    pulse_read();
    check("b2b_overrun_clr", overrun, 0);
    check("b2b_full_clr", rx_full, 0);
    $display("[TB] back-to-back rx=0x%02h overrun cleared=%0d", rx_data, !overrun);

    // Abort after 5 bits, then a clean frame.
    pulse_tx(8'hF0);
    snap();
    ss_begin();
    xfer(8'h99, 5, seq);
    ss_end();
    check("abort_seq", seq, 8'h1E);
    check("abort_valid_cnt", n_valid - s_valid, 0);
    check("abort_oe", MISO_oe, 0);
    check("abort_rx_full", rx_full, 0);
    pulse_tx(8'h69);
    snap();
    ss_begin();
    xfer(8'h55, DW, seq);
    ss_end();
    check("post_abort_seq", seq, 8'h69);
    check("post_abort_rx", rx_data, 8'h55);
    check("post_abort_valid", n_valid - s_valid, 1);
    pulse_read();
    $display("[TB] abort then frame rx=0x%02h miso=0x%02h", rx_data, seq);

    // Asynchronous reset in the middle of a frame with a word waiting in the TX buffer.
    ss_begin();
    pulse_tx(8'hC3);
    check("mid_tx_empty", tx_empty, 0);
    xfer(8'hAA, 4, seq);
    rst_n = 1'b0;
    #1;
    check("mrst_MISO", MISO, 0);
    check("mrst_oe", MISO_oe, 0);
    check("mrst_rx_data", rx_data, 0);
    check("mrst_rx_full", rx_full, 0);
    check("mrst_tx_empty", tx_empty, 1);
    check("mrst_strobes", {S_BaudRate, S_Shift_clk, S_Sample_clk, rx_valid, overrun}, 0);
    SS_n = 1'b1; SCK_in = CPOL;
    clk_wait(2);
    rst_n = 1'b1;
    clk_wait(4);
    ss_begin();
    xfer(8'h3C, DW, seq);
    ss_end();
    check("post_rst_seq", seq, 8'h00);
    check("post_rst_rx", rx_data, 8'h3C);
    pulse_read();
    $display("[TB] mid-frame reset, next frame miso=0x%02h rx=0x%02h", seq, rx_data);

    // Master mode: the engine must ignore the bus entirely.
    MSTR = 1'b1;
    snap();
    ss_begin();
    xfer(8'hE7, DW, seq);
    ss_end();
    check("mstr_baud", n_baud - s_baud, 0);
    check("mstr_sample", n_sample - s_sample, 0);
    check("mstr_shift", n_shift - s_shift, 0);
    check("mstr_valid", n_valid - s_valid, 0);
    check("mstr_oe", n_oe - s_oe, 0);
    MSTR = 1'b0;
    $display("[TB] master mode bus activity ignored");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
